// File: rtl/funcao_g.sv
// Purpose : AES-128 key-schedule g function: RotWord, SubWord (AES S-box), XOR Rcon.
// Latency : 1 clock from entrada_valida to saida_valida; one word per clock.
// Backpressure: none; the consumer must accept saida whenever saida_valida is high.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears saida and saida_valida
//   entrada_valida palavra/rodada valid this cycle
//   palavra[31:0]  key word, byte0 = palavra[31:24]
//   rodada[3:0]    0-based expansion round index
//   saida[31:0]    registered g(palavra, rodada); holds when no new input arrives
//   saida_valida   saida carries a new result this cycle
module funcao_g (
  input  logic        clk,
  input  logic        reset,
  input  logic        entrada_valida,
  input  logic [31:0] palavra,
  input  logic [3:0]  rodada,
  output logic [31:0] saida,
  output logic        saida_valida
);

  // FIPS-197 forward S-box, one row of 16 entries per line; entry 00 sits in the
  // most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset 8*(255-x); for an 8-bit x, 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [7:0]  w_rcon;
  logic [31:0] w_result;

  logic [31:0] r_saida;
  logic        r_saida_valida;

  // Rotate left by one byte.
  assign w_rot = {palavra[23:0], palavra[31:24]};

  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

  // Round constants for the ten AES-128 expansion rounds; unused indices give 00.
  always_comb begin
    w_rcon = 8'h00;
    case (rodada)
      4'd0:    w_rcon = 8'h01;
      4'd1:    w_rcon = 8'h02;
      4'd2:    w_rcon = 8'h04;
      4'd3:    w_rcon = 8'h08;
      4'd4:    w_rcon = 8'h10;
      4'd5:    w_rcon = 8'h20;
      4'd6:    w_rcon = 8'h40;
      4'd7:    w_rcon = 8'h80;
      4'd8:    w_rcon = 8'h1b;
      4'd9:    w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_result = w_sub ^ {w_rcon, 24'h000000};

  // Reset wins over a coincident valid input, which is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_saida        <= 32'h00000000;
      r_saida_valida <= 1'b0;
    end else begin
      r_saida_valida <= entrada_valida;
      if (entrada_valida) begin
        r_saida <= w_result;
      end
    end
  end

  assign saida        = r_saida;
  assign saida_valida = r_saida_valida;

endmodule

// File: tb/tb_funcao_g.sv
// Purpose : scoreboard bench for funcao_g using directed FIPS-197 and Rcon vectors.
// Latency : expects each result exactly one clock after its input is sampled.
// Backpressure: none exercised; the DUT has no ready path.
module tb_funcao_g;

  logic        clk;
  logic        reset;
  logic        entrada_valida;
  logic [31:0] palavra;
  logic [3:0]  rodada;
  logic [31:0] saida;
  logic        saida_valida;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  funcao_g dut (
    .clk            (clk),
    .reset          (reset),
    .entrada_valida (entrada_valida),
    .palavra        (palavra),
    .rodada         (rodada),
    .saida          (saida),
    .saida_valida   (saida_valida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid output must match the oldest expectation, on its cycle.
  always @(negedge clk) begin
    if (saida_valida === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h at cycle %0d expected none", saida, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_dat", saida, e.dat);
        chk("out_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one cycle of input at the falling edge; the rising edge in between samples it.
  task automatic apply(input logic v, input logic [31:0] p, input logic [3:0] r,
                       input logic [31:0] expv);
    exp_t e;
    entrada_valida = v;
    palavra        = p;
    rodada         = r;
    if (v && !reset) begin
      e.dat = expv;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    entrada_valida = 1'b1;
    palavra        = 32'hffffffff;
    rodada         = 4'd0;

    // Reset held for two sampled edges with a valid input present.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_saida", saida, 32'h00000000);
      chk("reset_vld", {31'd0, saida_valida}, 32'd0);
    end
    reset = 1'b0;

    // Single transactions with idle gaps.
    apply(1'b1, 32'h09cf4f3c, 4'd0,  32'h8b84eb01);
    apply(1'b0, 32'h00000000, 4'd0,  32'h0);
    apply(1'b1, 32'h2a6c7605, 4'd1,  32'h52386be5);
    apply(1'b1, 32'h00000000, 4'd8,  32'h78636363);
    apply(1'b1, 32'hffffffff, 4'd9,  32'h20161616);
    apply(1'b1, 32'h00000000, 4'd12, 32'h63636363);
    apply(1'b1, 32'h00000000, 4'd7,  32'he3636363);
    apply(1'b1, 32'h00000000, 4'd4,  32'h73636363);
    apply(1'b1, 32'hffffffff, 4'd15, 32'h16161616);
    apply(1'b1, 32'h00000000, 4'd10, 32'h63636363);

    // Back-to-back stream, then idle: output must hold the last result.
    apply(1'b1, 32'h09cf4f3c, 4'd0, 32'h8b84eb01);
    apply(1'b1, 32'h2a6c7605, 4'd1, 32'h52386be5);
    apply(1'b1, 32'h00000000, 4'd0, 32'h62636363);
    apply(1'b0, 32'hdeadbeef, 4'd3, 32'h0);
    chk("hold_saida", saida, 32'h62636363);
    chk("hold_vld", {31'd0, saida_valida}, 32'd0);
    apply(1'b0, 32'h12345678, 4'd5, 32'h0);
    chk("hold_saida2", saida, 32'h62636363);

    // Reset coincident with a valid input: the input is dropped.
    reset = 1'b1;
    apply(1'b1, 32'h09cf4f3c, 4'd0, 32'h0);
    chk("midrst_saida", saida, 32'h00000000);
    chk("midrst_vld", {31'd0, saida_valida}, 32'd0);
    reset = 1'b0;
    apply(1'b0, 32'h00000000, 4'd0, 32'h0);
    chk("post_rst_saida", saida, 32'h00000000);
    chk("post_rst_vld", {31'd0, saida_valida}, 32'd0);

    // Recovery after reset.
    apply(1'b1, 32'h2a6c7605, 4'd1, 32'h52386be5);
    apply(1'b0, 32'h00000000, 4'd0, 32'h0);
    apply(1'b0, 32'h00000000, 4'd0, 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
